mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 15: cycles (4-bit) waited for s_ready before forced completion; used only when MEM_ARB_TIMEOUT_EN is defined.
REQ-002 SHALL have port clk, input, 1: sole clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-004 SHALL have ports m0_valid, m1_valid, input, 1: master access requests.
REQ-005 SHALL have ports m0_ready, m1_ready, output, 1: per-master completion strobes.
REQ-006 SHALL have ports m0_instr, m1_instr, input, 1: instruction-fetch flags.
REQ-007 SHALL have ports m0_wstrb, m1_wstrb, input, 4: byte write strobes; 0 means read.
REQ-008 SHALL have ports m0_addr/m0_wdata, m1_addr/m1_wdata, input, 32 each: byte address and write data.
REQ-009 SHALL have ports m0_rdata, m1_rdata, output, 32: read data.
REQ-010 SHALL have ports s_valid, s_instr, output, 1; s_wstrb, output, 4; s_addr, s_wdata, output, 32: shared memory port.
REQ-011 SHALL have ports s_ready, input, 1; s_rdata, input, 32: memory response.

Function
REQ-012 SHALL implement states IDLE, BUSY, TURN, with a 1-bit owner register.
REQ-013 In IDLE, if a valid is asserted, SHALL go to BUSY and latch owner: sole requester wins; both requesting, the master that was not the last owner wins (round-robin); last-owner after reset = m1, so m0 wins the first tie.
REQ-014 s_valid SHALL be 1 only in BUSY; s_instr, s_wstrb, s_addr and s_wdata SHALL mux the owner's inputs in BUSY and be 0 otherwise.
REQ-015 In BUSY, on s_ready=1, SHALL pulse owner's mN_ready for exactly that cycle (combinational pass-through) and go to TURN.
REQ-016 TURN SHALL last exactly one cycle with s_valid=0, ignore s_ready (which is stale from the registered memory), then go to IDLE.
REQ-017 Non-owner mN_ready SHALL stay 0 at all times.
REQ-018 m0_rdata and m1_rdata SHALL both equal s_rdata (unused data is harmless).
REQ-019 Minimum latency from mN_valid rising in IDLE to mN_ready SHALL be 2 cycles: BUSY in cycle 1, s_ready in cycle 2. Back-to-back grants SHALL be 4 cycles apart.
REQ-020 A master dropping valid while it owns BUSY is a protocol violation; arbiter SHALL keep ownership until completion.
REQ-021 A request arriving in BUSY or TURN SHALL wait, with no loss, until the next IDLE decision.

Reset
REQ-022 reset SHALL force, asynchronously: state IDLE, last-owner m1, timeout counter 0. All ready outputs and s_valid SHALL be 0 while reset is held.
REQ-023 Reset mid-BUSY SHALL abandon the transfer with no ready pulse, and SHALL issue no memory access in the cycle after release.

Configuration
REQ-024 With MEM_ARB_TIMEOUT_EN defined, a counter SHALL count BUSY cycles without s_ready. When it reaches TIMEOUT, the arbiter SHALL pulse the owner's ready, drive that master's rdata to 32'hDEAD_BEEF for that cycle, and go to TURN. The counter SHALL clear on entering BUSY.
REQ-025 Without MEM_ARB_TIMEOUT_EN, the arbiter SHALL wait in BUSY indefinitely and SHALL contain no counter logic.

Verification
REQ-026 m0 reads addr 0x10, memory returns 0x12345678 -> s_valid in cycle 1, m0_ready pulses in cycle 2 with m0_rdata=0x12345678, m1_ready=0 throughout.
REQ-027 m0 and m1 both assert valid in the same cycle after reset -> m0 is granted first, m1 granted 4 cycles later; repeat -> grants alternate m0, m1, m0, m1.
REQ-028 m1 writes wstrb=4'b0110, wdata=0xAABBCCDD to 0x20 -> s_wstrb=0110, s_addr=0x20; a later m0 read of 0x20 returns bytes 1-2 = BB,CC.
REQ-029 s_ready held high continuously across TURN -> exactly one ready pulse per grant, s_valid=0 in TURN, no double completion.
REQ-030 reset asserted in BUSY, then released -> no ready pulse, IDLE next cycle, m0 wins the next tie.
REQ-031 MEM_ARB_TIMEOUT_EN defined, TIMEOUT=15, s_ready tied 0 -> ready pulses 15 BUSY cycles after grant with rdata=0xDEADBEEF; undefined -> no ready pulse after 100 cycles.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-master round-robin arbiter in front of one memory port.
// Optional build macro MEM_ARB_TIMEOUT_EN adds a BUSY watchdog that force-completes
// a stalled access after TIMEOUT cycles and returns 32'hDEAD_BEEF to the owner.
//
// Handshake: a master raises mN_valid with its request fields and holds them
// steady until it sees mN_ready=1 in a cycle; that cycle is the completion.
// The memory sees s_valid=1 only while an access is in flight and completes it
// in the first such cycle where s_ready=1. After every completion there is one
// TURN cycle with s_valid=0, so a stale s_ready from the registered memory
// cannot complete the next access.
`timescale 1ns/1ps
module mem_arbiter #(
  parameter logic [3:0] TIMEOUT = 4'd15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_valid,
  input  logic        m0_instr,
  input  logic [3:0]  m0_wstrb,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  output logic        m0_ready,
  output logic [31:0] m0_rdata,
  input  logic        m1_valid,
  input  logic        m1_instr,
  input  logic [3:0]  m1_wstrb,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  output logic        m1_ready,
  output logic [31:0] m1_rdata,
  output logic        s_valid,
  output logic        s_instr,
  output logic [3:0]  s_wstrb,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  input  logic        s_ready,
  input  logic [31:0] s_rdata,
  output logic [1:0]  dbg_state_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    TURN = 2'd2
  } state_t;

  state_t state_q, state_d;
  // owner_q doubles as the last-owner memory for round-robin between grants
  logic   owner_q, owner_d;
  logic   grant;
  logic   tmo;
  logic   done;

`ifdef MEM_ARB_TIMEOUT_EN
  logic [3:0] cnt_q, cnt_d;

  // Watchdog fires only when the memory has not answered in this cycle
  assign tmo = (state_q == BUSY) && !s_ready && (cnt_q == TIMEOUT);

  // Count BUSY cycles that passed without s_ready; zero outside BUSY
  always_comb begin
    cnt_d = 4'd0;
    if (state_q == BUSY && !done) begin
      cnt_d = cnt_q + 4'd1;
    end
  end

  // Watchdog counter register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= 4'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
  assign tmo = 1'b0;
`endif

  assign done        = (state_q == BUSY) && (s_ready || tmo);
  assign dbg_state_o = state_q;

  // Winner of an IDLE decision: sole requester, or the non-last owner on a tie
  always_comb begin
    grant = m1_valid;
    if (m0_valid && m1_valid) begin
      grant = ~owner_q;
    end
  end

  // State and owner registers; reset makes m1 the last owner so m0 wins first tie
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      owner_q <= 1'b1;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
    end
  end

  // Next-state logic; ownership is held through BUSY even if valid drops
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    case (state_q)
      IDLE: begin
        if (m0_valid || m1_valid) begin
          state_d = BUSY;
          owner_d = grant;
        end
      end
      BUSY: begin
        if (done) begin
          state_d = TURN;
        end
      end
      TURN:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic: memory port muxes the owner only in BUSY, ready is a pass-through
  always_comb begin
    s_valid  = 1'b0;
    s_instr  = 1'b0;
    s_wstrb  = 4'd0;
    s_addr   = 32'd0;
    s_wdata  = 32'd0;
    m0_ready = done && !owner_q;
    m1_ready = done && owner_q;
    m0_rdata = s_rdata;
    m1_rdata = s_rdata;
    if (state_q == BUSY) begin
      s_valid = 1'b1;
      if (owner_q) begin
        s_instr = m1_instr;
        s_wstrb = m1_wstrb;
        s_addr  = m1_addr;
        s_wdata = m1_wdata;
      end else begin
        s_instr = m0_instr;
        s_wstrb = m0_wstrb;
        s_addr  = m0_addr;
        s_wdata = m0_wdata;
      end
    end
    if (tmo) begin
      if (owner_q) begin
        m1_rdata = 32'hDEAD_BEEF;
      end else begin
        m0_rdata = 32'hDEAD_BEEF;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: bench for mem_arbiter with a 16-word memory responder,
// per-master request drivers and a cycle-level reference model of the
// arbitration rules that checks every DUT output on each falling edge.
`timescale 1ns/1ps
module tb_mem_arbiter;

  localparam logic [3:0] TIMEOUT = 4'd15;
  localparam int         TXN_W   = 69;   // {instr, wstrb[3:0], addr[31:0], wdata[31:0]}
`ifdef MEM_ARB_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic        m0_valid = 0, m0_instr = 0, m1_valid = 0, m1_instr = 0;
  logic [3:0]  m0_wstrb = 0, m1_wstrb = 0;
  logic [31:0] m0_addr = 0, m0_wdata = 0, m1_addr = 0, m1_wdata = 0;
  logic        m0_ready, m1_ready;
  logic [31:0] m0_rdata, m1_rdata;
  logic        s_valid, s_instr;
  logic [3:0]  s_wstrb;
  logic [31:0] s_addr, s_wdata;
  logic        s_ready = 0;
  logic [31:0] s_rdata = 0;
  logic [1:0]  dbg_state;

  mem_arbiter #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .m0_valid(m0_valid), .m0_instr(m0_instr), .m0_wstrb(m0_wstrb), .m0_addr(m0_addr),
    .m0_wdata(m0_wdata), .m0_ready(m0_ready), .m0_rdata(m0_rdata),
    .m1_valid(m1_valid), .m1_instr(m1_instr), .m1_wstrb(m1_wstrb), .m1_addr(m1_addr),
    .m1_wdata(m1_wdata), .m1_ready(m1_ready), .m1_rdata(m1_rdata),
    .s_valid(s_valid), .s_instr(s_instr), .s_wstrb(s_wstrb), .s_addr(s_addr),
    .s_wdata(s_wdata), .s_ready(s_ready), .s_rdata(s_rdata),
    .dbg_state_o(dbg_state)
  );

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int mode     = 0;      // 0: registered ready, 1: ready held high, 2: ready held low
  bit rnd_ready = 1'b0;  // mode 0 only: randomly delay the registered ready

  logic [31:0]      mem       [16];  // memory seen by the responder
  logic [31:0]      model_mem [16];  // reference model's view of memory
  logic [TXN_W-1:0] exp_q0[$];
  logic [TXN_W-1:0] exp_q1[$];
  int               g_owner[$];
  int               g_cyc[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_checks++;
    if (act === want) n_pass++;
    else $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, want, cyc);
  endtask

  // ---------------- driver tasks ----------------
  task automatic drop(input int m);
    if (m == 0) begin
      m0_valid = 0; m0_instr = 0; m0_wstrb = 0; m0_addr = 0; m0_wdata = 0;
    end else begin
      m1_valid = 0; m1_instr = 0; m1_wstrb = 0; m1_addr = 0; m1_wdata = 0;
    end
  endtask

  // Called at posedge+1; returns at posedge+1. Valid stays up if the budget expires.
  task automatic do_txn(input int m, input logic [31:0] addr, input logic [3:0] wstrb,
                        input logic [31:0] wdata, input logic instr, input int budget,
                        output int lat, output logic [31:0] rdata, output bit got);
    logic [TXN_W-1:0] t;
    t = {instr, wstrb, addr, wdata};
    if (m == 0) begin
      exp_q0.push_back(t);
      m0_valid = 1; m0_instr = instr; m0_wstrb = wstrb; m0_addr = addr; m0_wdata = wdata;
    end else begin
      exp_q1.push_back(t);
      m1_valid = 1; m1_instr = instr; m1_wstrb = wstrb; m1_addr = addr; m1_wdata = wdata;
    end
    lat = 0; got = 0; rdata = 0;
    while (!got && lat < budget) begin
      @(negedge clk);
      if ((m == 0 && m0_ready) || (m == 1 && m1_ready)) begin
        got   = 1;
        rdata = (m == 0) ? m0_rdata : m1_rdata;
      end
      @(posedge clk); #1;
      if (!got) lat++;
    end
    if (got) drop(m);
  endtask

  task automatic run_master(input int m, input int n, input int max_idle);
    int          lat;
    logic [31:0] rd;
    bit          got;
    logic [3:0]  ws;
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, max_idle)) begin @(posedge clk); #1; end
      ws = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
      do_txn(m, {26'h0, 4'($urandom_range(0, 15)), 2'b00}, ws, $urandom,
             1'($urandom_range(0, 1)), 200, lat, rd, got);
      check($sformatf("m%0d_txn_done", m), 32'(got), 32'd1);
    end
  endtask

  task automatic apply_reset();
    reset = 1;
    repeat (2) begin @(posedge clk); #1; end
    reset = 0;
  endtask

  // ---------------- memory responder ----------------
  initial begin
    bit sv, sr;
    forever begin
      @(negedge clk);
      sv = s_valid;
      sr = s_ready;
      if (!reset && sv && sr) begin
        for (int b = 0; b < 4; b++)
          if (s_wstrb[b]) mem[s_addr[5:2]][8*b +: 8] = s_wdata[8*b +: 8];
      end
      @(posedge clk); #1;
      case (mode)
        0:       s_ready = sv && (!rnd_ready || $urandom_range(0, 2) != 0);
        1:       s_ready = 1'b1;
        default: s_ready = 1'b0;
      endcase
      s_rdata = mem[s_addr[5:2]];
    end
  end

  // ---------------- monitor / scoreboard ----------------
  initial begin
    bit               m_busy, m_owner, m_last, have, done, tmo;
    int               cool, m_cnt;
    logic [TXN_W-1:0] t;
    logic [31:0]      exp_data, er0, er1;
    m_busy = 0; m_owner = 0; m_last = 1; cool = 0; m_cnt = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (reset) begin
        check("reset_ready", {30'd0, m1_ready, m0_ready}, 32'd0);
        check("reset_s_valid", 32'(s_valid), 32'd0);
        m_busy = 0; cool = 0; m_last = 1; m_cnt = 0;
      end else begin
        check("s_valid", 32'(s_valid), 32'(m_busy));
        have = 0; t = '0;
        if (m_busy) begin
          check("owner_pending", m_owner ? exp_q1.size() : exp_q0.size(), 32'd1);
          if (!m_owner && exp_q0.size() > 0) begin t = exp_q0[0]; have = 1; end
          if (m_owner && exp_q1.size() > 0) begin t = exp_q1[0]; have = 1; end
        end
        check("s_instr", 32'(s_instr), 32'(t[68]));
        check("s_wstrb", 32'(s_wstrb), 32'(t[67:64]));
        check("s_addr", s_addr, t[63:32]);
        check("s_wdata", s_wdata, t[31:0]);
        tmo  = TMO_EN && m_busy && !s_ready && (m_cnt == int'(TIMEOUT));
        done = m_busy && (s_ready || tmo);
        check("m0_ready", 32'(m0_ready), 32'(done && !m_owner));
        check("m1_ready", 32'(m1_ready), 32'(done && m_owner));
        exp_data = tmo ? 32'hDEAD_BEEF : model_mem[t[37:34]];
        er0 = (done && !m_owner) ? exp_data : s_rdata;
        er1 = (done && m_owner) ? exp_data : s_rdata;
        check("m0_rdata", m0_rdata, er0);
        check("m1_rdata", m1_rdata, er1);
        if (done && have) begin
          if (!tmo)
            for (int b = 0; b < 4; b++)
              if (t[64+b]) model_mem[t[37:34]][8*b +: 8] = t[8*b +: 8];
          if (m_owner) void'(exp_q1.pop_front());
          else         void'(exp_q0.pop_front());
        end
        // advance the model one cycle
        if (m_busy) begin
          if (done) begin m_busy = 0; cool = 1; end
          else m_cnt++;
        end else if (cool > 0) begin
          cool--;
        end else if (m0_valid || m1_valid) begin
          m_owner = (m0_valid && m1_valid) ? !m_last : m1_valid;
          m_last  = m_owner;
          m_busy  = 1;
          m_cnt   = 0;
          g_owner.push_back(int'(m_owner));
          g_cyc.push_back(cyc + 1);
        end
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    n_checks++;
    $display("FAIL watchdog: got no end of test, expected completion within budget");
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // ---------------- main stimulus ----------------
  initial begin
    int          lat;
    logic [31:0] rd, v;
    bit          got;
    for (int i = 0; i < 16; i++) begin
      v = (32'h0101_0101 * i) ^ 32'h5A00_0000;
      mem[i] = v; model_mem[i] = v;
    end
    mem[4] = 32'h1234_5678; model_mem[4] = 32'h1234_5678;
    mem[8] = 32'h1122_3344; model_mem[8] = 32'h1122_3344;
    repeat (3) @(posedge clk);
    #1 reset = 0;

    // single read by m0
    do_txn(0, 32'h10, 4'h0, 32'h0, 1'b0, 20, lat, rd, got);
    check("r026_got", 32'(got), 32'd1);
    check("r026_latency", lat, 32'd2);
    check("r026_rdata", rd, 32'h1234_5678);

    // partial write by m1, read back by m0
    do_txn(1, 32'h20, 4'b0110, 32'hAABB_CCDD, 1'b0, 20, lat, rd, got);
    check("r028_wr_got", 32'(got), 32'd1);
    do_txn(0, 32'h20, 4'h0, 32'h0, 1'b0, 20, lat, rd, got);
    check("r028_rd_got", 32'(got), 32'd1);
    check("r028_rdata", rd, 32'h11BB_CC44);

    // simultaneous requests after reset alternate m0, m1, m0, m1
    apply_reset();
    g_owner.delete(); g_cyc.delete();
    fork
      run_master(0, 2, 0);
      run_master(1, 2, 0);
    join
    check("r027_grants", g_owner.size(), 32'd4);
    for (int i = 0; i < 4 && i < g_owner.size(); i++)
      check($sformatf("r027_owner%0d", i), g_owner[i], i % 2);
    for (int i = 1; i < 4 && i < g_cyc.size(); i++)
      check($sformatf("r027_spacing%0d", i), g_cyc[i] - g_cyc[i-1], 32'd4);

    // s_ready held high through TURN
    mode = 1;
    fork
      run_master(0, 3, 1);
      run_master(1, 3, 1);
    join
    mode = 0;

    // reset during BUSY: m0 owns, reset, m0 must win the next tie again
    do_txn(1, 32'h4, 4'h0, 32'h0, 1'b0, 20, lat, rd, got);
    check("r030_pre_got", 32'(got), 32'd1);
    g_owner.delete(); g_cyc.delete();
    mode = 2;
    fork
      run_master(0, 1, 0);
      run_master(1, 1, 0);
      begin
        repeat (3) begin @(posedge clk); #1; end
        apply_reset();
        mode = 0;
      end
    join
    check("r030_grants", g_owner.size(), 32'd3);
    for (int i = 0; i < 3 && i < g_owner.size(); i++)
      check($sformatf("r030_owner%0d", i), g_owner[i], (i == 2) ? 1 : 0);

    // randomized traffic with random memory latency
    rnd_ready = 1;
    fork
      run_master(0, 25, 3);
      run_master(1, 25, 3);
    join
    rnd_ready = 0;

    // memory never answers
    mode = 2;
`ifdef MEM_ARB_TIMEOUT_EN
    do_txn(0, 32'h10, 4'h0, 32'h0, 1'b0, 40, lat, rd, got);
    check("r031_got", 32'(got), 32'd1);
    check("r031_latency", lat, 32'd16);
    check("r031_rdata", rd, 32'hDEAD_BEEF);
    mode = 0;
`else
    do_txn(0, 32'h10, 4'h0, 32'h0, 1'b0, 100, lat, rd, got);
    check("r031_no_ready", 32'(got), 32'd0);
    reset = 1;
    drop(0);
    exp_q0.delete();
    repeat (2) begin @(posedge clk); #1; end
    reset = 0;
    mode = 0;
`endif

    repeat (4) begin @(posedge clk); #1; end
    check("q0_drained", exp_q0.size(), 32'd0);
    check("q1_drained", exp_q1.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
